// File: rtl/pwm_fade_controller.sv
// PWM duty-cycle fader: ramps duty_out toward target_duty in clamped steps paced by a prescaler.
// Optional done pulse is built only when PWM_FADE_DONE_EN is defined; otherwise done is tied low.
module pwm_fade_controller #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        target_duty,
  input  logic [STEP_W-1:0] step_size,
  input  logic [7:0]        tick_div,
  input  logic              fade_en,
  output logic [7:0]        duty_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  pcnt_q, pcnt_d;

  logic              tick_s;
  logic [7:0]        step_s;
  logic [8:0]        up_sum_s;
  logic signed [8:0] dn_diff_s;
  logic [7:0]        up_val_s;
  logic [7:0]        dn_val_s;
  logic [7:0]        ramp_val_s;

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign step_s     = (step_size == '0) ? 8'd1 : 8'(step_size);
  assign tick_s     = (pcnt_q >= tick_div);
  assign up_sum_s   = {1'b0, duty_q} + {1'b0, step_s};
  assign dn_diff_s  = $signed({1'b0, duty_q}) - $signed({1'b0, step_s});
  assign up_val_s   = (up_sum_s > {1'b0, target_duty}) ? target_duty : up_sum_s[7:0];
  assign dn_val_s   = (dn_diff_s < $signed({1'b0, target_duty})) ? target_duty : dn_diff_s[7:0];
  assign ramp_val_s = (state_q == UP) ? up_val_s : dn_val_s;

  // Next-state, duty and prescaler logic; pcnt defaults to 0 so every state change restarts it.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pcnt_d  = 8'd0;
    case (state_q)
      IDLE: begin
        if (!fade_en) begin
          duty_d = target_duty;
        end else if (target_duty > duty_q) begin
          state_d = UP;
        end else if (target_duty < duty_q) begin
          state_d = DOWN;
        end else begin
          state_d = IDLE;
        end
      end
      UP, DOWN: begin
        if (!fade_en) begin
          duty_d  = target_duty;
          state_d = IDLE;
        end else if (target_duty == duty_q) begin
          state_d = IDLE;
        end else if ((state_q == UP) && (target_duty < duty_q)) begin
          state_d = DOWN;
        end else if ((state_q == DOWN) && (target_duty > duty_q)) begin
          state_d = UP;
        end else if (tick_s) begin
          duty_d  = ramp_val_s;
          state_d = (ramp_val_s == target_duty) ? IDLE : state_q;
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = duty_q;
      end
    endcase
  end

  // State, duty and prescaler registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= 8'd0;
      pcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = (state_q != IDLE);

`ifdef PWM_FADE_DONE_EN
  logic done_q, done_d;

  // Leaving a ramp state with fade_en still high only happens on reaching the target.
  assign done_d = (state_q != IDLE) && (state_d == IDLE) && fade_en;

  // Done pulse register, aligned with the final duty value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller: directed scenarios plus randomized traffic,
// every cycle compared against an arithmetic reference model of the fade behaviour.
module tb_pwm_fade_controller;
  localparam int STEP_W = 4;
`ifdef PWM_FADE_DONE_EN
  localparam bit DONE_EN = 1'b1;
`else
  localparam bit DONE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        target_duty;
  logic [STEP_W-1:0] step_size;
  logic [7:0]        tick_div;
  logic              fade_en;
  logic [7:0]        duty_out;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  pwm_fade_controller #(.STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .target_duty(target_duty), .step_size(step_size),
    .tick_div(tick_div), .fade_en(fade_en), .duty_out(duty_out), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model: current duty, whether a fade is in progress, direction (+1/-1),
  // cycles waited since the last step, and whether a fade just finished
  int m_duty = 0;
  int m_wait = 0;
  int m_dir  = 0;
  bit m_ramp = 1'b0;
  bit m_done = 1'b0;
  bit prev_done = 1'b0;
  int cyc_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_step();
    int t, st, nd;
    t  = int'(target_duty);
    st = (step_size == '0) ? 1 : int'(step_size);
    m_done = 1'b0;
    if (!rst_n) begin
      m_duty = 0; m_ramp = 1'b0; m_wait = 0; m_dir = 0;
    end else if (!m_ramp) begin
      m_wait = 0;
      if (!fade_en) m_duty = t;
      else if (t != m_duty) begin
        m_ramp = 1'b1;
        m_dir  = (t > m_duty) ? 1 : -1;
      end
    end else if (!fade_en) begin
      m_duty = t; m_ramp = 1'b0; m_wait = 0;
    end else if (t == m_duty) begin
      m_ramp = 1'b0; m_done = 1'b1; m_wait = 0;
    end else if ((t - m_duty) * m_dir < 0) begin
      m_dir = -m_dir; m_wait = 0;
    end else if (m_wait >= int'(tick_div)) begin
      nd = m_duty + m_dir * st;
      if (m_dir > 0 && nd > t) nd = t;
      if (m_dir < 0 && nd < t) nd = t;
      m_duty = nd;
      m_wait = 0;
      if (nd == t) begin
        m_ramp = 1'b0; m_done = 1'b1;
      end
    end else begin
      m_wait++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cyc_no++;
    check("duty", duty_out, m_duty);
    check("busy", busy, m_ramp);
    check("done", done, m_done & DONE_EN);
    check("done_twice", done & prev_done, 1'b0);
    prev_done = done;
  endtask

  task automatic preset(input logic [7:0] d);
    fade_en = 1'b0; target_duty = d;
    cyc();
  endtask

  initial begin
    int chg_cyc[$];
    int chg_val[$];
    int done_cnt, start;
    logic [7:0] prev;
    bit reached;

    rst_n = 1'b0; target_duty = 8'h5A; step_size = 4'd1; tick_div = 8'd0; fade_en = 1'b1;
    cyc(); cyc();
    check("rst_duty", duty_out, 8'h00);
    check("rst_busy", busy, 1'b0);

    // direct follow
    rst_n = 1'b1; fade_en = 1'b0; target_duty = 8'h80;
    cyc();
    check("follow_duty", duty_out, 8'h80);
    check("follow_busy", busy, 1'b0);
    check("follow_done", done, 1'b0);

    // 0x00 -> 0x10, step 4, tick_div 3
    preset(8'h00);
    fade_en = 1'b1; target_duty = 8'h10; step_size = 4'd4; tick_div = 8'd3;
    start = cyc_no; done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      prev = duty_out;
      cyc();
      if (duty_out != prev) begin
        chg_cyc.push_back(cyc_no - start);
        chg_val.push_back(int'(duty_out));
      end
      if (done === 1'b1) done_cnt++;
    end
    check("ramp_nchg", chg_cyc.size(), 4);
    if (chg_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("ramp_val", chg_val[i], 4 * (i + 1));
        check("ramp_cyc", chg_cyc[i], 5 + 4 * i);
      end
    end
    check("ramp_done_cnt", done_cnt, DONE_EN ? 1 : 0);
    check("ramp_busy_end", busy, 1'b0);

    // clamping at both ends
    preset(8'hF0);
    fade_en = 1'b1; target_duty = 8'hFF; step_size = 4'd15; tick_div = 8'd0;
    cyc(); cyc();
    check("clamp_hi", duty_out, 8'hFF);
    preset(8'h05);
    fade_en = 1'b1; target_duty = 8'h00; step_size = 4'd8;
    cyc(); cyc();
    check("clamp_lo", duty_out, 8'h00);

    // reversal mid-ramp
    preset(8'h40);
    fade_en = 1'b1; target_duty = 8'h80; step_size = 4'd4; tick_div = 8'd3;
    cyc(); cyc(); cyc();
    target_duty = 8'h20;
    cyc();
    check("rev_hold", duty_out, 8'h40);
    check("rev_busy", busy, 1'b1);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (done === 1'b1) done_cnt++;
    end
    check("rev_final", duty_out, 8'h20);
    check("rev_done_cnt", done_cnt, DONE_EN ? 1 : 0);

    // reset mid-ramp at 0x30
    preset(8'h00);
    fade_en = 1'b1; target_duty = 8'h80; step_size = 4'd8; tick_div = 8'd1;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cyc();
      if (m_duty == 8'h30) reached = 1'b1;
    end
    check("mid_reached", reached, 1'b1);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_duty", duty_out, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;

    // fade_en drop mid-ramp
    preset(8'h00);
    fade_en = 1'b1; target_duty = 8'h80; step_size = 4'd1; tick_div = 8'd2;
    for (int i = 0; i < 10; i++) cyc();
    fade_en = 1'b0; target_duty = 8'h55;
    cyc();
    check("drop_duty", duty_out, 8'h55);
    check("drop_busy", busy, 1'b0);
    check("drop_done", done, 1'b0);

    // tick_div shrinks below the running prescaler count
    preset(8'h00);
    fade_en = 1'b1; target_duty = 8'h90; step_size = 4'd3; tick_div = 8'd20;
    for (int i = 0; i < 8; i++) cyc();
    tick_div = 8'd2;
    cyc();
    check("tdiv_step", duty_out, 8'h03);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) target_duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 39) == 0) fade_en = ~fade_en;
      if ($urandom_range(0, 29) == 0) step_size = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) tick_div = 8'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_fade_controller.md
PWM_FADE_CONTROLLER -- requirements
Module: pwm_fade_controller

Interface
REQ-001 Parameter STEP_W, default 4: width of step_size.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 target_duty  input  8  requested duty cycle, driven from the SPI register bank.
REQ-005 step_size  input  STEP_W  duty increment/decrement per ramp tick; value 0 is treated as 1.
REQ-006 tick_div  input  8  prescaler; one ramp step every tick_div+1 clk cycles.
REQ-007 fade_en  input  1  1 = ramp toward target; 0 = follow target directly.
REQ-008 duty_out  output  8  registered duty cycle, drives the PWM peripheral duty input.
REQ-009 busy  output  1  high whenever state is not IDLE; decoded from the state register only.
REQ-010 done  output  1  single-cycle pulse when a ramp reaches its target.

Function
REQ-011 The FSM SHALL have three states: IDLE, UP and DOWN.
REQ-012 In IDLE with fade_en=0, duty_out SHALL load target_duty every cycle (1-cycle latency), and the FSM SHALL stay in IDLE.
REQ-013 In IDLE with fade_en=1, the FSM SHALL go to UP if target_duty>duty_out, to DOWN if target_duty<duty_out, else stay in IDLE.
REQ-014 Prescaler pcnt (8 bit) SHALL count only in UP/DOWN; tick = (pcnt>=tick_div); on tick pcnt<=0, else pcnt<=pcnt+1; pcnt<=0 in IDLE and on every state change.
REQ-015 UP on tick: duty_out <= min(duty_out+step, target_duty), computed 9-bit; no wrap past 0xFF.
REQ-016 DOWN on tick: duty_out <= max(duty_out-step, target_duty), computed 9-bit signed; no underflow below 0x00.
REQ-017 When the clamped update equals target_duty, the FSM SHALL enter IDLE and assert done in the same cycle that duty_out takes the final value.
REQ-018 target_duty SHALL be re-evaluated every cycle: in UP with target_duty<duty_out, the FSM SHALL go to DOWN (and vice versa) the next cycle with duty_out held.
REQ-019 In UP/DOWN, if target_duty==duty_out without a tick, the FSM SHALL enter IDLE and pulse done.
REQ-020 fade_en falling in UP/DOWN: next cycle duty_out<=target_duty, FSM to IDLE, no done pulse.
REQ-021 A tick_div change SHALL take effect immediately; pcnt above the new value produces a tick on the next cycle.
REQ-022 done SHALL never be high for two consecutive cycles.

Reset
REQ-023 On rst_n=0 at a clk edge: duty_out=0x00, state=IDLE, pcnt=0, done=0, busy=0, regardless of the state the FSM is in.
REQ-024 The first cycle after reset release SHALL behave as IDLE with duty_out=0x00.

Configuration
REQ-025 Macro PWM_FADE_DONE_EN: when defined, done behaves per REQ-017/019/022; when undefined, the done register is not built, done is tied to 0 and all other behaviour is unchanged.

Verification
REQ-026 fade_en=0, target_duty=0x80 from reset -> duty_out=0x80 one cycle later, busy=0, done=0.
REQ-027 fade_en=1, duty 0x00, target 0x10, step 4, tick_div 3 -> duty_out 0x04,0x08,0x0C,0x10 at 4-cycle spacing; done pulses once with 0x10; busy then drops.
REQ-028 Clamping: duty 0xF0, target 0xFF, step 15 -> 0xFF in one step, no wrap; duty 0x05, target 0x00, step 8 -> 0x00, no underflow.
REQ-029 Ramping UP at 0x40 toward 0x80, target changes to 0x20 -> DOWN next cycle, prescaler restarts, ramps to 0x20, done once.
REQ-030 rst_n low mid-ramp at duty 0x30 -> next edge duty_out=0x00, busy=0, done=0; fade_en drop mid-ramp -> duty_out=target next cycle, no done.
REQ-031 Build without PWM_FADE_DONE_EN, repeat REQ-027 -> identical duty_out trace, done constantly 0.
